// File: rtl/id_ex_register_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bus layout, register-address width
// and ALUOp encodings.
package id_ex_register_pkg;

    localparam int unsigned CTRL_W     = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT_W    = 10;

    // Bit positions within {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], Branch}
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_MEMREAD  = 5;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_ALUSRC   = 3;
    localparam int unsigned CTRL_ALUOP_HI = 2;
    localparam int unsigned CTRL_ALUOP_LO = 1;
    localparam int unsigned CTRL_BRANCH   = 0;

    typedef enum logic [1:0] {
        AluOpAdd    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpRType  = 2'b10,
        AluOpIType  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/id_ex_register_load_use_detector.sv
// Combinational load-use hazard check: a valid load in EX whose destination is read by the
// valid instruction currently in ID.
module load_use_detector
    import id_ex_register_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_rs1_use_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs2_use_i,
    output logic                  hazard_o
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_match = id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i);
        // x0 is never a real dependency, so a load to x0 cannot stall.
        hazard_o  = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != '0) && id_valid_i &&
                    (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use interlock, bubble insertion and bubble counter.
// Frozen entirely while the data cache stalls the pipeline.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_stall_i,
    input  logic                  ID_valid_i,
    input  logic [REG_ADDR_W-1:0] ID_RS1addr_i,
    input  logic [REG_ADDR_W-1:0] ID_RS2addr_i,
    input  logic [REG_ADDR_W-1:0] ID_RDaddr_i,
    input  logic                  ID_RS1use_i,
    input  logic                  ID_RS2use_i,
    input  logic [XLEN-1:0]       ID_data1_i,
    input  logic [XLEN-1:0]       ID_data2_i,
    input  logic [XLEN-1:0]       ID_imm_i,
    input  logic [CTRL_W-1:0]     ID_ctrl_i,
    input  logic [FUNCT_W-1:0]    ID_funct_i,
    output logic                  EX_valid_o,
    output logic [REG_ADDR_W-1:0] ID_EX_RS1addr_o,
    output logic [REG_ADDR_W-1:0] ID_EX_RS2addr_o,
    output logic [REG_ADDR_W-1:0] ID_EX_RDaddr_o,
    output logic [XLEN-1:0]       EX_data1_o,
    output logic [XLEN-1:0]       EX_data2_o,
    output logic [XLEN-1:0]       EX_imm_o,
    output logic [CTRL_W-1:0]     EX_ctrl_o,
    output logic [FUNCT_W-1:0]    EX_funct_o,
    output logic                  hazard_stall_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       data1_q;
    logic [XLEN-1:0]       data2_q;
    logic [XLEN-1:0]       imm_q;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [FUNCT_W-1:0]    funct_q;
    logic [CNT_W-1:0]      bubble_cnt_q;
    logic                  hazard;

    load_use_detector u_load_use_detector (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
        .ex_rd_addr_i  (rd_q),
        .id_valid_i    (ID_valid_i),
        .id_rs1_addr_i (ID_RS1addr_i),
        .id_rs1_use_i  (ID_RS1use_i),
        .id_rs2_addr_i (ID_RS2addr_i),
        .id_rs2_use_i  (ID_RS2use_i),
        .hazard_o      (hazard)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            ctrl_q       <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= '0;
        end else if (mem_stall_i) begin
            // Hold everything; a pending hazard stays visible and is resolved after the stall.
        end else if (hazard) begin
            // Zeroed RD keeps the forwarding unit from ever matching a bubble.
            valid_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            ctrl_q       <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end else begin
            valid_q <= ID_valid_i;
            rs1_q   <= ID_RS1addr_i;
            rs2_q   <= ID_RS2addr_i;
            rd_q    <= ID_RDaddr_i;
            data1_q <= ID_data1_i;
            data2_q <= ID_data2_i;
            imm_q   <= ID_imm_i;
            ctrl_q  <= ID_valid_i ? ID_ctrl_i : '0;
            funct_q <= ID_funct_i;
        end
    end

    assign EX_valid_o      = valid_q;
    assign ID_EX_RS1addr_o = rs1_q;
    assign ID_EX_RS2addr_o = rs2_q;
    assign ID_EX_RDaddr_o  = rd_q;
    assign EX_data1_o      = data1_q;
    assign EX_data2_o      = data2_q;
    assign EX_imm_o        = imm_q;
    assign EX_ctrl_o       = ctrl_q;
    assign EX_funct_o      = funct_q;
    assign hazard_stall_o  = hazard;
    assign bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between the ID and EX stages of the five-stage RISC-V core. It latches decoded operands, register addresses and control bits from ID and presents them to the EX stage and to the forwarding unit. It also contains the load-use hazard interlock: it raises the stall request and inserts a bubble, and it counts the bubbles it inserts. It honours a global memory stall from the data cache.

## Interface
- XLEN, 32, datapath width of operands and immediate
- CNT_W, 32, width of the bubble performance counter

- clk_i  in  1  pipeline clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- mem_stall_i  in  1  data-cache stall; freezes this register
- ID_valid_i  in  1  ID holds a real instruction
- ID_RS1addr_i, ID_RS2addr_i, ID_RDaddr_i  in  5 each  register addresses from decode
- ID_RS1use_i, ID_RS2use_i  in  1 each  instruction actually reads RS1 / RS2
- ID_data1_i, ID_data2_i, ID_imm_i  in  XLEN each  register-file reads and sign-extended immediate
- ID_ctrl_i  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], Branch}
- ID_funct_i  in  10  {funct7, funct3} for ALU control
- EX_valid_o  out  1  EX holds a real instruction
- ID_EX_RS1addr_o, ID_EX_RS2addr_o, ID_EX_RDaddr_o  out  5 each  to EX and forwarding unit
- EX_data1_o, EX_data2_o, EX_imm_o  out  XLEN each
- EX_ctrl_o  out  8; EX_funct_o  out  10
- hazard_stall_o  out  1  load-use stall; holds PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  number of load-use bubbles inserted since reset

## Operation
- Hazard condition, combinational: EX_valid_o & EX_ctrl_o.MemRead & ID_EX_RDaddr_o≠0 & ID_valid_i & ((ID_RS1use_i & ID_RS1addr_i==ID_EX_RDaddr_o) | (ID_RS2use_i & ID_RS2addr_i==ID_EX_RDaddr_o)).
- hazard_stall_o equals the hazard condition and is not masked by mem_stall_i. The upstream stages hold in either case.
- Register update at each rising edge, highest priority first:
  - mem_stall_i=1: hold all contents. The counter does not change.
  - Hazard: insert a bubble. EX_valid_o←0, EX_ctrl_o←0, address outputs←0, data fields don't-care, which are driven to 0. bubble_cnt_o increments.
  - Otherwise: load every ID field. EX_valid_o←ID_valid_i.
  - An invalid ID instruction (ID_valid_i=0) loads with EX_ctrl_o forced to 0, so it cannot write any register.
- Forcing RDaddr to 0 in a bubble guarantees the forwarding unit never matches a bubble.
- bubble_cnt_o wraps modulo 2^CNT_W with no saturation.
- Back-to-back loads feeding each other produce exactly one bubble per dependent pair. After the bubble, EX_valid_o=0 and the hazard clears.

## Timing
- Reset (asynchronous assert, clock-synchronous deassert by the system): all outputs go to 0, including EX_valid_o, EX_ctrl_o, the addresses, the data fields and bubble_cnt_o. hazard_stall_o is therefore 0.
- Latency: ID values appear on the outputs 1 cycle after the edge on which they are sampled.
- hazard_stall_o is valid in the same cycle as its inputs, with no registered delay. It lasts exactly 1 cycle per hazard unless mem_stall_i extends it.
- Simultaneous hazard and mem_stall_i:
  - hazard_stall_o stays high for the whole stall.
  - The bubble is inserted on the first edge where mem_stall_i=0.
  - The counter increments once.
- Reset mid-stall: the pipeline is empty the next cycle and no bubble is counted.

## Structure
- A shared package holds:
  - the control-bit field indices (CTRL_REGWRITE … CTRL_BRANCH) and the CTRL_W=8 constant;
  - the REG_ADDR_W=5 constant;
  - the ALUOp encodings.
- One sub-module, load_use_detector, holds the combinational hazard equation. It is reused by any later stall analysis.
- Everything else is a single always block for the register and the counter.

## Test plan
- Reset: rst_i=0 during arbitrary inputs -> all outputs 0. After release with ID_valid_i=1, RD=5, RegWrite=1 -> next cycle ID_EX_RDaddr_o=5, EX_valid_o=1.
- Load-use: `lw x5` in EX, then `add x6,x5,x7` in ID with RS1use=1 -> hazard_stall_o=1 for 1 cycle. The next EX holds a bubble (EX_ctrl_o=0, RDaddr=0), bubble_cnt_o=1, and `add` enters EX the following cycle.
- No false stall:
  - load to x0 with a consumer of x0 -> hazard_stall_o=0;
  - load to x5 with a consumer whose RS2use=0 but whose RS2addr=5 -> hazard_stall_o=0.
- mem_stall_i held for 3 cycles during a hazard -> outputs frozen, hazard_stall_o high for 4 cycles, exactly 1 bubble, counter +1.
- Invalid ID (ID_valid_i=0, RegWrite=1 on the bus) -> EX_valid_o=0 and EX_ctrl_o=0 next cycle.
- Counter wrap, with CNT_W=4: 16 load-use hazards -> bubble_cnt_o returns to 0.
